// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver.
// Recovers start/data/(parity)/stop framing from the rx line and presents each
// word on rx_dout with a one-clock rx_done_tick strobe.
// Optional parity stage: define UART_RX_PARITY_EN to insert a parity bit after
// the last data bit (sense chosen by PARITY_ODD).
// dbg_state exposes the FSM state for observation.
module uart_rx_core #(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_tick,
    input  logic             rx,
    output logic [DBITS-1:0] rx_dout,
    output logic             rx_done_tick,
    output logic             frame_err,
    output logic             parity_err,
    output logic [2:0]       dbg_state
);

    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [NW-1:0] N_LAST  = NW'(DBITS - 1);
    localparam logic [4:0]    S_MID   = 5'd7;
    localparam logic [4:0]    S_BIT   = 5'd15;
    localparam logic [4:0]    S_STOP  = 5'(SB_TICK - 1);
    localparam logic          P_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [DBITS-1:0] shift_q, shift_d;
    logic [DBITS-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             sync1_q, rx_s_q, rx_d_q;
    logic             par_bit;

`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;

    // Received parity bit, latched in the PARITY state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) par_q <= 1'b0;
        else          par_q <= par_d;
    end

    assign par_bit = par_q;
`else
    // Without a parity stage the "received" parity is taken to be the
    // expected one, so the mismatch below folds to a constant 0.
    assign par_bit = ^shift_q ^ P_ODD;
`endif

    // Two-flop synchronizer plus one delayed copy for falling-edge detect;
    // all reset to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // FSM, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state logic: counters only move on s_tick, the IDLE edge detect
    // runs every clock so a start edge right after the stop sample is caught.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_d_q && !rx_s_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // Mid start bit: still low means a real frame.
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        shift_d = {rx_s_q, shift_q[DBITS-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        par_d   = rx_s_q;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        dout_d  = shift_q;
                        ferr_d  = ~rx_s_q;
                        perr_d  = ^shift_q ^ par_bit ^ P_ODD;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign parity_err   = perr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed, table-driven bench for uart_rx_core.
// Builds rx frames bit by bit on a 16x tick grid and scoreboards every
// rx_done_tick against hand-written expected words.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int DBITS    = 8;
    localparam int TICK_DIV = 4;
    localparam logic P_ODD  = 1'b0;

    // ---------------- clock / reset / tick ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic s_tick = 1'b0;
    logic rx = 1'b1;
    int   tick_cnt = 0;

    logic [DBITS-1:0] rx_dout;
    logic             rx_done_tick;
    logic             frame_err;
    logic             parity_err;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_cnt == TICK_DIV - 1) begin
            tick_cnt <= 0;
            s_tick   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            s_tick   <= 1'b0;
        end
    end

    uart_rx_core #(.DBITS(DBITS), .SB_TICK(16), .PARITY_ODD(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DBITS+1:0] exp_q[$];
    logic [DBITS+1:0] got_q[$];
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Capture every strobe away from the active edge; a strobe must be one clock wide.
    always @(negedge clk) begin
        if (reset_n && rx_done_tick) begin
            got_q.push_back({parity_err, frame_err, rx_dout});
            chk("done_width", {31'd0, prev_done}, 32'd0);
        end
        prev_done <= rx_done_tick;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        rx = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        drive_bit(1'b0, 16);
        for (int i = 0; i < DBITS; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d ^ P_ODD ^ par_flip, 16);
`endif
        drive_bit(stop_v, 16);
        if (!stop_v) drive_bit(1'b1, 16);
    endtask

    task automatic check_frames();
        logic [DBITS+1:0] e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int t = 0; t < 3000 && got_q.size() == 0; t++) @(negedge clk);
            chk("strobe_arrived", {31'd0, (got_q.size() != 0)}, 32'd1);
            if (got_q.size() != 0) begin
                g = got_q.pop_front();
                chk("rx_dout", {24'd0, g[7:0]}, {24'd0, e[7:0]});
                chk("frame_err", {31'd0, g[8]}, {31'd0, e[8]});
                chk("parity_err", {31'd0, g[9]}, {31'd0, e[9]});
            end
        end
        wait_ticks(20);
        chk("no_extra_strobe", got_q.size(), 32'd0);
        got_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic       par_flip;
        logic [7:0] exp_dout;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
`ifdef UART_RX_PARITY_EN
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
`else
        vecs[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", {24'd0, rx_dout}, 32'd0);
        chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        reset_n = 1'b1;
        wait_ticks(4);
        chk("idle_state", {29'd0, dbg_state}, 32'd0);
        chk("idle_ferr", {31'd0, frame_err}, 32'd0);
        chk("idle_perr", {31'd0, parity_err}, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_v, vecs[i].par_flip);
            exp_q.push_back({vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_dout});
            check_frames();
        end

        // Back-to-back 0x00 then 0xFF with no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h00});
        exp_q.push_back({1'b0, 1'b0, 8'hFF});
        check_frames();

        // Glitch: low for 4 ticks is rejected at the start-bit midpoint
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 12);
        chk("glitch_state", {29'd0, dbg_state}, 32'd0);
        chk("glitch_no_strobe", got_q.size(), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h3C});
        check_frames();

        // Reset in the middle of the data bits of 0x81
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 8);
        chk("mid_state_data", {29'd0, dbg_state}, 32'd2);
        @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_dout", {24'd0, rx_dout}, 32'd0);
        chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
        reset_n = 1'b1;
        wait_ticks(40);
        chk("mid_rst_no_strobe", got_q.size(), 32'd0);
        chk("mid_rst_hold", {24'd0, rx_dout}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h5A});
        check_frames();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
